// File: rtl/rename_issue_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rename_issue_queue: circular uop FIFO between decode and dispatch,   |
// | 2-wide push, up to MAX_UOPS-wide pop, with sent/stall counters.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+

package rename_issue_queue_pkg;
    typedef enum logic [3:0] {
        UOP_INT_ALU  = 4'd0,
        UOP_INT_MUL  = 4'd1,
        UOP_LD_U8    = 4'd2,
        UOP_LD_U32   = 4'd3,
        UOP_ST_U8    = 4'd4,
        UOP_ST_U32   = 4'd5,
        UOP_BRANCH   = 4'd6,
        UOP_CAP_JUMP = 4'd7,
        UOP_FP_ADD   = 4'd8,
        UOP_CSR      = 4'd9
    } uop_tag_t;
endpackage

module rename_issue_queue
    import rename_issue_queue_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int MAX_UOPS = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         decode_valid_i,
    input  uop_tag_t                     decode_uop0_i,
    input  uop_tag_t                     decode_uop1_i,
    input  logic [1:0]                   decode_uop_count_i,
    output logic                         decode_ready_o,
    input  logic                         flush_i,
    input  logic                         dispatch_ready_i,
    output logic                         rename_valid_o,
    output uop_tag_t                     rename_uop0_o,
    output uop_tag_t                     rename_uop1_o,
    output logic [1:0]                   rename_uop_count_o,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy_o,
    output logic [15:0]                  sent_uop_count_o,
    output logic [15:0]                  stall_cycle_count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);

    uop_tag_t           mem_q [DEPTH];
    uop_tag_t           mem_d [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [PTR_W-1:0]   head_nxt, tail_nxt;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic [15:0]        sent_q, sent_d, stall_q, stall_d;
    logic [16:0]        sent_sum, stall_sum;
    logic [1:0]         push_cnt, pop_cnt;

    assign head_nxt = head_q + PTR_W'(1);
    assign tail_nxt = tail_q + PTR_W'(1);

    // Ready looks only at registered occupancy; a concurrent pop earns no credit.
    assign decode_ready_o = !flush_i && (occ_q <= OCC_W'(DEPTH - 2));
    assign rename_valid_o = (occ_q != '0) && !flush_i;

    always_comb begin
        rename_uop_count_o = 2'd0;
        if (rename_valid_o) begin
            if (MAX_UOPS == 1 || occ_q == OCC_W'(1)) begin
                rename_uop_count_o = 2'd1;
            end else begin
                rename_uop_count_o = 2'd2;
            end
        end
    end

    assign rename_uop0_o = (occ_q != '0) ? mem_q[head_q] : UOP_INT_ALU;
    assign rename_uop1_o = (rename_uop_count_o == 2'd2) ? mem_q[head_nxt] : UOP_INT_ALU;

    assign pop_cnt = (rename_valid_o && dispatch_ready_i) ? rename_uop_count_o : 2'd0;

    always_comb begin
        push_cnt = 2'd0;
        if (decode_valid_i && decode_ready_o) begin
            if (decode_uop_count_i == 2'd1) begin
                push_cnt = 2'd1;
            end else if (decode_uop_count_i != 2'd0) begin
                push_cnt = 2'd2;
            end
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (push_cnt != 2'd0) begin
            mem_d[tail_q] = decode_uop0_i;
        end
        if (push_cnt == 2'd2) begin
            mem_d[tail_nxt] = decode_uop1_i;
        end

        head_d = head_q + PTR_W'(pop_cnt);
        tail_d = tail_q + PTR_W'(push_cnt);
        occ_d  = occ_q + OCC_W'(push_cnt) - OCC_W'(pop_cnt);
        if (flush_i) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
        end

        sent_sum  = {1'b0, sent_q} + 17'(pop_cnt);
        stall_sum = {1'b0, stall_q} + 17'(rename_valid_o && !dispatch_ready_i);
        sent_d    = sent_sum[16]  ? 16'hFFFF : sent_sum[15:0];
        stall_d   = stall_sum[16] ? 16'hFFFF : stall_sum[15:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= '0;
            sent_q  <= '0;
            stall_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            occ_q   <= occ_d;
            sent_q  <= sent_d;
            stall_q <= stall_d;
        end
    end

    // Payload storage is not reset; occupancy alone decides what is live.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign occupancy_o         = occ_q;
    assign sent_uop_count_o    = sent_q;
    assign stall_cycle_count_o = stall_q;

endmodule
`default_nettype wire
